// File: rtl/uninasoc_irq_mapper.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uninasoc_irq_mapper: routes platform interrupt sources onto PLIC lines via an
// elaboration-time table, with per-source level/edge mode and synchroniser.
// Revision: 1.0
// ----------------------------------------------------------------------------
module uninasoc_irq_mapper #(
  parameter int                   NUM_SRC     = 6,
  parameter int                   NUM_LINES   = 32,
  parameter logic [NUM_SRC*8-1:0] SRC_TO_LINE = 48'h06_05_04_03_02_01,
  parameter logic [NUM_SRC-1:0]   EDGE_MASK   = '0,
  parameter int                   SYNC_STAGES = 2
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic [NUM_SRC-1:0]   irq_src_i,
  input  logic [NUM_LINES-1:0] line_enable_i,
  input  logic [NUM_LINES-1:0] line_ack_i,
  output logic [NUM_LINES-1:0] plic_irq_o,
  output logic [NUM_SRC-1:0]   src_active_o,
  output logic [NUM_SRC-1:0]   src_missed_o
);

  function automatic bit table_ok();
    for (int i = 0; i < NUM_SRC; i++) begin
      if (int'(SRC_TO_LINE[8*i +: 8]) >= NUM_LINES) return 1'b0;
    end
    return 1'b1;
  endfunction

  if (NUM_SRC > 64 || NUM_SRC < 1) begin : g_chk_num_src
    $error("uninasoc_irq_mapper: NUM_SRC must be in 1..64");
  end
  if (SYNC_STAGES > 3 || SYNC_STAGES < 0) begin : g_chk_sync
    $error("uninasoc_irq_mapper: SYNC_STAGES must be in 0..3");
  end
  if (!table_ok()) begin : g_chk_table
    $error("uninasoc_irq_mapper: SRC_TO_LINE entry out of line range");
  end

  logic [NUM_SRC-1:0]   sync_out;
  logic [NUM_SRC-1:0]   prev_q;
  logic [NUM_SRC-1:0]   pending_q;
  logic [NUM_SRC-1:0]   missed_q;
  logic [NUM_SRC-1:0]   rise;
  logic [NUM_SRC-1:0]   clr;
  logic [NUM_SRC-1:0]   active;
  logic [NUM_LINES-1:0] line_or;
  logic [NUM_LINES-1:0] plic_q;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign sync_out = irq_src_i;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0][NUM_SRC-1:0] chain;

    always_ff @(posedge clock_i) begin
      if (reset_i) begin
        chain <= '0;
      end else begin
        chain[0] <= irq_src_i;
        for (int k = 1; k < SYNC_STAGES; k++) chain[k] <= chain[k-1];
      end
    end

    assign sync_out = chain[SYNC_STAGES-1];
  end

  // Ack on a line clears every edge source whose table entry names that line;
  // line 0 still collects unmapped sources here but is forced low below.
  always_comb begin
    rise    = sync_out & ~prev_q & EDGE_MASK;
    active  = (EDGE_MASK & pending_q) | (~EDGE_MASK & sync_out);
    clr     = '0;
    line_or = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int l = 0; l < NUM_LINES; l++) begin
        if (int'(SRC_TO_LINE[8*i +: 8]) == l) begin
          clr[i]     = clr[i] | line_ack_i[l];
          line_or[l] = line_or[l] | active[i];
        end
      end
    end
    line_or[0] = 1'b0;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      prev_q    <= '0;
      pending_q <= '0;
      missed_q  <= '0;
      plic_q    <= '0;
    end else begin
      prev_q    <= sync_out;
      pending_q <= rise | (pending_q & ~clr);
      missed_q  <= (rise & pending_q) | (missed_q & ~clr);
      plic_q    <= line_or & line_enable_i;
    end
  end

  assign plic_irq_o   = plic_q;
  assign src_active_o = active;
  assign src_missed_o = missed_q;

endmodule
`default_nettype wire

// File: tb/tb_uninasoc_irq_mapper.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uninasoc_irq_mapper: three mapper configurations checked every cycle
// against a table-driven behavioural model plus directed literal checks.
// ----------------------------------------------------------------------------
module tb_uninasoc_irq_mapper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0][5:0]  src;
  logic [2:0][31:0] en;
  logic [2:0][31:0] ack;
  logic [2:0][31:0] plic_o;
  logic [2:0][5:0]  act_o;
  logic [2:0][5:0]  mis_o;

  // 0: defaults; 1: shared line 5, edge on 1,4,5; 2: unmapped src 2, no sync
  uninasoc_irq_mapper u_def (
    .clock_i(clk), .reset_i(rst), .irq_src_i(src[0]), .line_enable_i(en[0]),
    .line_ack_i(ack[0]), .plic_irq_o(plic_o[0]), .src_active_o(act_o[0]),
    .src_missed_o(mis_o[0]));

  uninasoc_irq_mapper #(
    .SRC_TO_LINE(48'h06_05_04_03_02_05), .EDGE_MASK(6'b110010), .SYNC_STAGES(2)
  ) u_edge (
    .clock_i(clk), .reset_i(rst), .irq_src_i(src[1]), .line_enable_i(en[1]),
    .line_ack_i(ack[1]), .plic_irq_o(plic_o[1]), .src_active_o(act_o[1]),
    .src_missed_o(mis_o[1]));

  uninasoc_irq_mapper #(
    .SRC_TO_LINE(48'h06_05_04_00_02_01), .EDGE_MASK(6'b110110), .SYNC_STAGES(0)
  ) u_s0 (
    .clock_i(clk), .reset_i(rst), .irq_src_i(src[2]), .line_enable_i(en[2]),
    .line_ack_i(ack[2]), .plic_irq_o(plic_o[2]), .src_active_o(act_o[2]),
    .src_missed_o(mis_o[2]));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %h expected %h", nm, k, $time, act, exp);
    end
  endtask

  // Behavioural model: each source sees its raw input delayed by the sync depth
  int        map   [3][6];
  int        sstg  [3];
  bit [5:0]  edgem [3];
  bit [5:0]  pend  [3];
  bit [5:0]  mis   [3];
  bit [5:0]  prev  [3];
  bit [5:0]  dly   [3][4];
  bit [31:0] exp_plic [3];
  bit        chk_on = 1'b0;
  bit [5:0]  s_now, act_m, rise_m, clr_m;
  bit [31:0] lines;

  initial begin
    map[0] = '{1, 2, 3, 4, 5, 6};
    map[1] = '{5, 2, 3, 4, 5, 6};
    map[2] = '{1, 2, 0, 4, 5, 6};
    sstg   = '{2, 2, 0};
    edgem  = '{6'b000000, 6'b110010, 6'b110110};
  end

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        pend[k] = '0; mis[k] = '0; prev[k] = '0; exp_plic[k] = '0;
        for (int j = 0; j < 4; j++) dly[k][j] = '0;
      end else begin
        s_now = (sstg[k] == 0) ? src[k] : dly[k][sstg[k]-1];
        lines = '0;
        for (int i = 0; i < 6; i++) begin
          clr_m[i]  = ack[k][map[k][i]];
          act_m[i]  = edgem[k][i] ? pend[k][i] : s_now[i];
          rise_m[i] = edgem[k][i] & s_now[i] & ~prev[k][i];
          if (map[k][i] != 0 && act_m[i]) lines[map[k][i]] = 1'b1;
        end
        exp_plic[k] = lines & en[k];
        mis[k]  = (rise_m & pend[k]) | (mis[k] & ~clr_m);
        pend[k] = rise_m | (pend[k] & ~clr_m);
        prev[k] = s_now;
        for (int j = 3; j > 0; j--) dly[k][j] = dly[k][j-1];
        dly[k][0] = src[k];
      end
    end
    if (rst) chk_on = 1'b1;
  end

  function automatic bit [5:0] exp_active(input int k);
    bit [5:0] r;
    for (int i = 0; i < 6; i++)
      r[i] = edgem[k][i] ? pend[k][i]
                         : ((sstg[k] == 0) ? src[k][i] : dly[k][sstg[k]-1][i]);
    return r;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 3; k++) begin
        chk("plic", k, plic_o[k], exp_plic[k]);
        chk("active", k, {26'd0, act_o[k]}, {26'd0, exp_active(k)});
        chk("missed", k, {26'd0, mis_o[k]}, {26'd0, mis[k]});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  initial begin
    src = '0; ack = '0; en = {3{32'hFFFF_FFFF}};
    repeat (3) step();
    rst = 1'b0;
    neg();
    chk("reset_plic", 0, plic_o[0], 32'h0);
    chk("reset_plic", 1, plic_o[1], 32'h0);

    // Level source 3 on defaults: 3-cycle rise and fall latency
    step(); src[0][3] = 1'b1;
    repeat (2) step(); neg(); chk("lvl_early", 0, plic_o[0], 32'h0);
    step(); neg();            chk("lvl_rise", 0, plic_o[0], 32'h10);
    step(); src[0][3] = 1'b0;
    repeat (2) step(); neg(); chk("lvl_hold", 0, plic_o[0], 32'h10);
    step(); neg();            chk("lvl_fall", 0, plic_o[0], 32'h0);

    // Edge source 1: 4-cycle latency, then hold
    step(); src[1][1] = 1'b1;
    step(); src[1][1] = 1'b0;
    repeat (2) step(); neg();
    chk("edge_early", 1, {31'd0, plic_o[1][2]}, 32'd0);
    chk("edge_pend", 1, {31'd0, act_o[1][1]}, 32'd1);
    step(); neg();            chk("edge_rise", 1, {31'd0, plic_o[1][2]}, 32'd1);
    repeat (3) step(); neg(); chk("edge_hold", 1, {31'd0, plic_o[1][2]}, 32'd1);

    // Second pulse while pending sets missed
    step(); src[1][1] = 1'b1;
    step(); src[1][1] = 1'b0;
    repeat (3) step(); neg(); chk("missed_set", 1, {31'd0, mis_o[1][1]}, 32'd1);

    // Ack line 2: pending clears at t+1, output at t+2
    step(); ack[1][2] = 1'b1;
    step(); ack[1][2] = 1'b0;
    neg();
    chk("ack_t1_line", 1, {31'd0, plic_o[1][2]}, 32'd1);
    chk("ack_t1_pend", 1, {31'd0, act_o[1][1]}, 32'd0);
    chk("ack_t1_miss", 1, {31'd0, mis_o[1][1]}, 32'd0);
    step(); neg();            chk("ack_t2_line", 1, {31'd0, plic_o[1][2]}, 32'd0);

    // Ack coinciding with a new rise on a pending source: set wins
    step(); src[1][1] = 1'b1;
    step(); src[1][1] = 1'b0;
    repeat (4) step();
    step(); src[1][1] = 1'b1;
    step(); src[1][1] = 1'b0;
    step(); ack[1][2] = 1'b1;
    step(); ack[1][2] = 1'b0;
    neg();
    chk("coin_pend", 1, {31'd0, act_o[1][1]}, 32'd1);
    chk("coin_miss", 1, {31'd0, mis_o[1][1]}, 32'd1);
    repeat (2) step(); neg(); chk("coin_line", 1, {31'd0, plic_o[1][2]}, 32'd1);
    step(); ack[1][2] = 1'b1;
    step(); ack[1][2] = 1'b0;
    repeat (2) step(); neg(); chk("coin_clear", 1, {31'd0, plic_o[1][2]}, 32'd0);

    // Shared line 5: level src 0 keeps it up after acking edge src 4
    step(); src[1][0] = 1'b1; src[1][4] = 1'b1;
    step(); src[1][4] = 1'b0;
    repeat (4) step(); neg(); chk("shared_up", 1, {31'd0, plic_o[1][5]}, 32'd1);
    step(); ack[1][5] = 1'b1;
    step(); ack[1][5] = 1'b0;
    repeat (2) step(); neg();
    chk("shared_held", 1, {31'd0, plic_o[1][5]}, 32'd1);
    chk("shared_pend", 1, {31'd0, act_o[1][4]}, 32'd0);
    step(); src[1][0] = 1'b0;
    repeat (3) step(); neg(); chk("shared_down", 1, {31'd0, plic_o[1][5]}, 32'd0);

    // Disabled line 6 keeps accumulating src 5, re-enable asserts next cycle
    step(); en[1][6] = 1'b0; src[1][5] = 1'b1;
    step(); src[1][5] = 1'b0;
    repeat (4) step(); neg();
    chk("gate_off", 1, {31'd0, plic_o[1][6]}, 32'd0);
    chk("gate_pend", 1, {31'd0, act_o[1][5]}, 32'd1);
    step(); en[1][6] = 1'b1;
    step(); neg();            chk("gate_on", 1, {31'd0, plic_o[1][6]}, 32'd1);

    // No-sync config with unmapped source 2, then reset while pending
    step(); src[2] = 6'b010110;
    step(); src[2] = 6'b000000;
    neg();                    chk("s0_pend", 2, {26'd0, act_o[2]}, 32'h16);
    step(); neg();            chk("s0_lines", 2, plic_o[2], 32'h24);
    step(); src[2][2] = 1'b1;
    step(); src[2][2] = 1'b0;
    neg();                    chk("s0_unmap_miss", 2, {31'd0, mis_o[2][2]}, 32'd1);
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    neg();
    for (int k = 0; k < 3; k++) begin
      chk("rst_plic", k, plic_o[k], 32'h0);
      chk("rst_act", k, {26'd0, act_o[k]}, 32'h0);
      chk("rst_miss", k, {26'd0, mis_o[k]}, 32'h0);
    end
    repeat (4) step(); neg();
    chk("post_rst_act", 2, {26'd0, act_o[2]}, 32'h0);
    chk("post_rst_plic", 1, plic_o[1], 32'h0);

    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uninasoc_irq_mapper.md
Name: uninasoc_irq_mapper

Overview:
Parametrised router from platform interrupt sources (PBUS peripherals, HLS, CDMA) to PLIC input lines. It replaces the fixed PLIC line assignments with an elaboration-time mapping table. Each source has a per-source level or rising-edge mode, an optional input synchroniser, and a pending latch for edge sources. The block sits between the source interrupt wires and the PLIC `irq` input vector. Line 0 is reserved and always reads 0.

Parameters:
- NUM_SRC, 6: number of interrupt sources (1..64).
- NUM_LINES, 32: PLIC input line count (2..256).
- SRC_TO_LINE, 48'h06_05_04_03_02_01: packed table of 8-bit entries. Entry i is at [8i+7:8i] and gives the destination line for source i. Value 0 means the source is unmapped. Table width is NUM_SRC*8.
- EDGE_MASK, '0: NUM_SRC bits. Bit i = 1 makes source i rising-edge latched; bit i = 0 makes it level.
- SYNC_STAGES, 2: synchroniser flops per source (0..3). 0 means the input is sampled directly.

Ports:
- clock_i  in  1  system clock.
- reset_i  in  1  synchronous, active-high reset.
- irq_src_i  in  NUM_SRC  raw source interrupt lines, active-high.
- line_enable_i  in  NUM_LINES  per-line output gate. Bit 0 is ignored.
- line_ack_i  in  NUM_LINES  single-cycle pulse per line. Clears edge-pending state for every edge source mapped to that line.
- plic_irq_o  out  NUM_LINES  registered interrupt vector to the PLIC.
- src_active_o  out  NUM_SRC  per-source active term: sync output for level sources, pending_q for edge sources.
- src_missed_o  out  NUM_SRC  sticky flag: an edge arrived while that source was already pending.

Behaviour:
- Single clock domain. The only clock is clock_i and reset_i is synchronous active-high.
- Reset clears every flop: sync chain, prev-sample, pending_q, missed_q and plic_irq_o. All outputs read 0 in the cycle after reset is sampled high.
- Reset mid-operation discards all pending and missed state. No replay occurs after reset.
- Synchroniser: SYNC_STAGES flops per source, giving s_i (the synchronised value). With SYNC_STAGES=0, s_i = irq_src_i[i].
- Level source: active_i = s_i. It has no pending state, and line_ack_i has no effect on it.
- Edge source:
  - prev_i <= s_i every cycle.
  - rise_i = s_i & ~prev_i.
  - pending_q[i] is set by rise_i and cleared by line_ack_i[SRC_TO_LINE[i]].
  - If set and clear occur in the same cycle, set wins.
  - active_i = pending_q[i].
  - Because prev resets to 0, an input already high when reset is released produces one rising edge.
- Missed flag: missed_q[i] is set when rise_i & pending_q[i]. It is cleared by the same ack as pending_q. If set and clear coincide, set wins.
- Output: plic_irq_o[L] <= line_enable_i[L] & OR over all i with SRC_TO_LINE[i]==L of active_i.
  - plic_irq_o[0] is always 0.
  - Unmapped sources (entry 0) only drive src_active_o and src_missed_o.
- Line enable gates only the output. Pending state keeps accumulating while a line is disabled, and re-enabling the line asserts it on the next cycle.
- Shared lines: several sources may map to one line and are OR-ed. An ack on that line clears all edge sources mapped to it.
- Latency, counted in cycles from an irq_src_i transition to plic_irq_o:
  - level source: SYNC_STAGES+1.
  - edge source: SYNC_STAGES+2.
  - When a level source deasserts, the output falls after SYNC_STAGES+1 cycles.
- Ack latency: an ack pulse in cycle t clears pending_q at t+1 and drops plic_irq_o at t+2, unless another source still holds the line.
- Elaboration checks: $error if any SRC_TO_LINE entry >= NUM_LINES, if NUM_SRC > 64, or if SYNC_STAGES > 3.

Test Plan:
- Defaults (all level, SYNC_STAGES=2): raise irq_src_i[3] (UART) at cycle 10 with all lines enabled -> plic_irq_o == 32'h10 at cycle 13. Lower it at cycle 20 -> plic_irq_o == 0 at cycle 23.
- EDGE_MASK=6'b000010 with a 1-cycle pulse on src 1 (TIM0) -> plic_irq_o[2] rises 4 cycles later and holds. line_ack_i[2] pulse at t -> plic_irq_o[2] == 0 at t+2.
- Edge src 1 pending, second pulse on src 1 -> src_missed_o[1] == 1. Ack on line 2 in the same cycle as a new rise_1 -> pending_q[1] stays 1 and the line stays asserted.
- SRC_TO_LINE maps src 0 and src 4 both to line 5, with src 0 level and src 4 edge. Hold src 0 high, pulse src 4, then ack line 5 -> plic_irq_o[5] stays 1 until src 0 drops.
- line_enable_i[6]=0 while edge src 5 (CDMA) pulses -> plic_irq_o[6] == 0 and src_active_o[5] == 1. Set the enable to 1 -> plic_irq_o[6] == 1 on the next cycle.
- Entry 0 for src 2, SYNC_STAGES=0, and a reset asserted while edge sources are pending -> plic_irq_o never shows bit 0 or any bit for src 2. All outputs are 0 the cycle after reset, and pending does not reappear after release.
